// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with saturating direction counters for the 5-stage MIPS pipeline.
// Optional statistics counters are built only when the BTB_STATS_EN macro is defined.
module branch_target_buffer #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_en,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic        flush,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispred
);

  localparam int N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (|c) ? c - 1'b1 : c;
  endfunction

  logic [N-1:0]     vld_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [31:0]      tgt_q [N];
  logic [CNT_W-1:0] cnt_q [N];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  // Only the index/tag fields of the PCs are used; the rest is folded here.
  logic unused_bits;
  assign unused_bits = ^{if_pc, upd_pc, if_en, upd_pred_taken};

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign lk_hit = vld_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign pred_hit    = rst && lk_hit;
  assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_hit ? tgt_q[lk_idx] : 32'd0;

  logic             wr_en_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [31:0]      wr_tgt_d;
  logic [CNT_W-1:0] wr_cnt_d;

  always_comb begin
    wr_en_d  = 1'b0;
    wr_tag_d = up_tag;
    wr_tgt_d = upd_target;
    wr_cnt_d = CNT_WEAK;
    if (upd_valid && !flush) begin
      if (up_hit) begin
        wr_en_d = 1'b1;
        if (upd_taken) begin
          wr_cnt_d = sat_inc(cnt_q[up_idx]);
        end else begin
          wr_cnt_d = sat_dec(cnt_q[up_idx]);
          wr_tgt_d = tgt_q[up_idx];
        end
      end else if (upd_taken) begin
        wr_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else if (wr_en_d) begin
      vld_q[up_idx] <= 1'b1;
      tag_q[up_idx] <= wr_tag_d;
      tgt_q[up_idx] <= wr_tgt_d;
      cnt_q[up_idx] <= wr_cnt_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups_q, stat_hits_q, stat_mispred_q;

  // Mispredictions are counted even when a concurrent flush drops the update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_lookups_q <= '0;
      stat_hits_q    <= '0;
      stat_mispred_q <= '0;
    end else begin
      if (if_en) stat_lookups_q <= stat_lookups_q + 32'd1;
      if (if_en && lk_hit) stat_hits_q <= stat_hits_q + 32'd1;
      if (upd_valid && (upd_pred_taken != upd_taken)) stat_mispred_q <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_hits    = stat_hits_q;
  assign stat_mispred = stat_mispred_q;
`else
  assign stat_lookups = 32'd0;
  assign stat_hits    = 32'd0;
  assign stat_mispred = 32'd0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (IDX_W=4, TAG_W=8, CNT_W=2).
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_en;
  logic [31:0] if_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        flush;
  logic [31:0] stat_lookups, stat_hits, stat_mispred;

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.IDX_W(4), .TAG_W(8), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .if_en(if_en), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .flush(flush),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic pt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_pred_taken = pt;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h99; upd_pred_taken = 1'b0;
    if_pc = 32'h40;
    tick(); tick();
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      errors++; $display("FAIL reset_forced got hit=%0b tk=%0b tgt=%h want 0/0/0", pred_hit, pred_taken, pred_target);
    end
    rst = 1'b1; upd_valid = 1'b0;
    #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'd0) begin
      errors++; $display("FAIL reset_lookup got hit=%0b tk=%0b tgt=%h want 0/0/0", pred_hit, pred_taken, pred_target);
    end
    checks++;
    if (stat_lookups !== 32'd0 || stat_hits !== 32'd0 || stat_mispred !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d/%0d want 0/0/0", stat_lookups, stat_hits, stat_mispred);
    end
    tick();
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL reset_after_edge got hit=%0b want 0", pred_hit);
    end
  endtask

  task automatic test_alloc_train();
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    if_pc = 32'h100; #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      errors++; $display("FAIL alloc got hit=%0b tk=%0b tgt=%h want 1/1/200", pred_hit, pred_taken, pred_target);
    end
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h200) begin
      errors++; $display("FAIL train_nt1 got hit=%0b tk=%0b tgt=%h want 1/0/200", pred_hit, pred_taken, pred_target);
    end
    upd(32'h100, 1'b0, 32'h0, 1'b0);
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h200) begin
      errors++; $display("FAIL train_nt2 got hit=%0b tk=%0b tgt=%h want 1/0/200", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_saturation();
    // counter 0 -> five taken -> saturates at 3
    for (int i = 0; i < 5; i++) upd(32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    if_pc = 32'h100; #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1) begin
      errors++; $display("FAIL sat_3to2 got hit=%0b tk=%0b want 1/1", pred_hit, pred_taken);
    end
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b0) begin
      errors++; $display("FAIL sat_2to1 got hit=%0b tk=%0b want 1/0", pred_hit, pred_taken);
    end
    // counter now 1; retrain to 2 for the next scenario
    upd(32'h100, 1'b1, 32'h200, 1'b0);
  endtask

  task automatic test_alias();
    if_pc = 32'h140; #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 32'd0) begin
      errors++; $display("FAIL alias_miss got hit=%0b tgt=%h want 0/0", pred_hit, pred_target);
    end
    upd(32'h140, 1'b1, 32'h400, 1'b0);
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h400) begin
      errors++; $display("FAIL alias_alloc got hit=%0b tgt=%h want 1/400", pred_hit, pred_target);
    end
    if_pc = 32'h100; #1;
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL alias_evict got hit=%0b want 0", pred_hit);
    end
    if_pc = 32'h143; #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h400) begin
      errors++; $display("FAIL low_bits_ignored got hit=%0b tgt=%h want 1/400", pred_hit, pred_target);
    end
    upd(32'h140, 1'b1, 32'h500, 1'b1);
    checks++;
    if (pred_hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h500) begin
      errors++; $display("FAIL target_update got hit=%0b tk=%0b tgt=%h want 1/1/500", pred_hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_no_bypass();
    upd_valid = 1'b1; upd_pc = 32'h180; upd_taken = 1'b1; upd_target = 32'h600; upd_pred_taken = 1'b0;
    if_pc = 32'h180; #1;
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL no_bypass got hit=%0b want 0", pred_hit);
    end
    tick();
    upd_valid = 1'b0; #1;
    checks++;
    if (pred_hit !== 1'b1 || pred_target !== 32'h600) begin
      errors++; $display("FAIL update_latency got hit=%0b tgt=%h want 1/600", pred_hit, pred_target);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    upd(32'h300, 1'b1, 32'h700, 1'b0);
    flush = 1'b0;
    if_pc = 32'h300; #1;
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL flush_drop got hit=%0b want 0", pred_hit);
    end
    if_pc = 32'h140; #1;
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL flush_140 got hit=%0b want 0", pred_hit);
    end
    if_pc = 32'h180; #1;
    checks++;
    if (pred_hit !== 1'b0 || pred_target !== 32'd0) begin
      errors++; $display("FAIL flush_180 got hit=%0b tgt=%h want 0/0", pred_hit, pred_target);
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_lk, exp_ht, exp_mp;
    rst = 1'b0; tick(); rst = 1'b1;
    upd(32'h100, 1'b1, 32'h200, 1'b0);           // mispredict 1
    if_en = 1'b1; if_pc = 32'h100;
    for (int i = 0; i < 4; i++) tick();          // 4 hits
    if_pc = 32'h800;
    for (int i = 0; i < 6; i++) tick();          // 6 misses
    if_en = 1'b0; if_pc = 32'h100;
    tick();                                      // hit but not enabled
    upd(32'h100, 1'b1, 32'h200, 1'b1);           // correct
    upd(32'h100, 1'b0, 32'h0, 1'b1);             // mispredict 2
    flush = 1'b1;
    upd(32'h100, 1'b0, 32'h0, 1'b1);             // mispredict 3, dropped by flush
    flush = 1'b0;
`ifdef BTB_STATS_EN
    exp_lk = 32'd10; exp_ht = 32'd4; exp_mp = 32'd3;
`else
    exp_lk = 32'd0; exp_ht = 32'd0; exp_mp = 32'd0;
`endif
    checks++;
    if (stat_lookups !== exp_lk) begin
      errors++; $display("FAIL stat_lookups got %0d want %0d", stat_lookups, exp_lk);
    end
    checks++;
    if (stat_hits !== exp_ht) begin
      errors++; $display("FAIL stat_hits got %0d want %0d", stat_hits, exp_ht);
    end
    checks++;
    if (stat_mispred !== exp_mp) begin
      errors++; $display("FAIL stat_mispred got %0d want %0d", stat_mispred, exp_mp);
    end
    checks++;
    if (pred_hit !== 1'b0) begin
      errors++; $display("FAIL stat_flush_hit got %0b want 0", pred_hit);
    end
  endtask

  initial begin
    rst = 1'b0; if_en = 1'b0; if_pc = 32'd0; flush = 1'b0;
    upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0; upd_pred_taken = 1'b0;
    test_reset();
    test_alloc_train();
    test_saturation();
    test_alias();
    test_no_bypass();
    test_flush();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Dynamic branch predictor and branch target buffer for the 5-stage MIPS pipeline. Sits beside the IF stage and gives a same-cycle next-PC prediction. It is trained by the ID stage, where branches are resolved from the rs/rt equality compare. It generalises the static predict-not-taken control-hazard scheme: a direct-mapped table of tagged targets with saturating direction counters, parametrised in depth, tag width and counter width, plus optional performance counters.

## Interface
- IDX_W, 4, index bits; table holds 2^IDX_W entries; IDX_W+TAG_W ≤ 30
- TAG_W, 8, tag bits stored per entry
- CNT_W, 2, saturating direction-counter width (≥1)
- clk  input  1  main clock
- rst  input  1  synchronous reset, active-low
- if_en  input  1  IF lookup enable (counts toward statistics only)
- if_pc  input  32  PC being fetched
- pred_hit  output  1  valid entry with matching tag for if_pc
- pred_taken  output  1  pred_hit AND counter MSB set
- pred_target  output  32  stored target on hit, else 0
- upd_valid  input  1  a branch resolved in ID this cycle
- upd_pc  input  32  PC of the resolved branch
- upd_taken  input  1  actual direction
- upd_target  input  32  actual taken target
- upd_pred_taken  input  1  prediction that branch received in IF
- flush  input  1  invalidate all entries
- stat_lookups  output  32  enabled lookups counted
- stat_hits  output  32  lookups that hit
- stat_mispred  output  32  updates where upd_pred_taken ≠ upd_taken

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Entry = {valid, tag, target[31:0], counter[CNT_W-1:0]}.
- Lookup is combinational: pred_hit = valid & tag match; pred_target = hit ? target : 0; pred_taken = hit & counter[CNT_W-1].
- Update on upd_valid at the clock edge:
  - hit, taken: counter saturating +1 (stops at 2^CNT_W−1); target ← upd_target.
  - hit, not taken: counter saturating −1 (stops at 0); target unchanged.
  - miss, taken: allocate (overwrite any occupant) with valid=1, new tag, target, counter = 2^(CNT_W−1) (weakly taken).
  - miss, not taken: no change.
- flush: all valid bits ← 0 at the edge. flush with upd_valid in the same cycle: flush wins and the update is dropped.
- Reset (rst=0 at an edge): all valid bits ← 0, counters/targets ← 0, statistics ← 0. While rst is low, pred_hit/pred_taken/pred_target are forced to 0.

## Timing
- Lookup latency: 0 cycles (same-cycle combinational path from if_pc).
- Update latency: 1 cycle; an update at edge N is visible to lookups from cycle N+1.
- Same index looked up and updated in one cycle: the lookup returns the pre-update contents (no write bypass).
- Statistics increment at the edge; they are 32-bit and wrap from 0xFFFFFFFF to 0. stat_lookups/stat_hits count cycles with if_en=1. stat_mispred counts upd_valid cycles, including when flush drops the update.
- No handshake: one update per cycle max; the producer guarantees upd_valid only for real branches.

## Configuration
- BTB_STATS_EN defined: the three statistics counters are implemented as above.
- BTB_STATS_EN undefined: no counter registers; stat_lookups, stat_hits and stat_mispred are driven constant 0. The ports remain in both builds, and prediction behaviour is identical.

## Test plan
- Reset: hold rst=0 for 2 cycles with upd_valid=1, then release; lookup if_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0, all stats 0.
- Allocate/train: update pc=0x100 taken target=0x200 -> next cycle lookup 0x100 gives hit=1, taken=1 (counter 2), target=0x200. Two not-taken updates -> counter 0, taken=0, hit=1.
- Saturation: CNT_W=2, five taken updates on 0x100 -> counter 3. One not-taken -> counter 2, still predicted taken.
- Aliasing: IDX_W=4; train 0x100 taken. Lookup 0x140 (same index, different tag) -> hit=0. Taken update on 0x140 evicts 0x100, so 0x100 misses afterwards.
- Flush vs update: flush=1 with a taken update on 0x300 in the same cycle -> next cycle every lookup misses, including 0x300.
- Statistics (BTB_STATS_EN): 10 if_en lookups with 4 hits and 3 mispredicted updates -> 10/4/3. Rebuilt without the macro -> all 0.
